// File: rtl/alu_pkg.sv
// alu_pkg: ALUFN opcodes, opcode legality check and controller state encoding
package alu_pkg;
   localparam logic [5:0] ALU_ADD   = 6'b100000;
   localparam logic [5:0] ALU_SUB   = 6'b100001;
   localparam logic [5:0] ALU_CMPEQ = 6'b100100;
   localparam logic [5:0] ALU_CMPLT = 6'b100101;
   localparam logic [5:0] ALU_CMPLE = 6'b100110;
   localparam logic [5:0] ALU_AND   = 6'b101000;
   localparam logic [5:0] ALU_OR    = 6'b101001;
   localparam logic [5:0] ALU_XOR   = 6'b101010;
   localparam logic [5:0] ALU_XNOR  = 6'b101011;
   localparam logic [5:0] ALU_SHL   = 6'b101100;
   localparam logic [5:0] ALU_SHR   = 6'b101101;
   localparam logic [5:0] ALU_SRA   = 6'b101110;
   localparam logic [5:0] ALU_A     = 6'b111111;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   function automatic logic alufn_legal(input logic [5:0] fn);
      return fn inside {ALU_ADD, ALU_SUB, ALU_CMPEQ, ALU_CMPLT, ALU_CMPLE, ALU_AND, ALU_OR,
                        ALU_XOR, ALU_XNOR, ALU_SHL, ALU_SHR, ALU_SRA, ALU_A};
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; the requester named by prio wins a tie
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic       grant_valid,
   output logic       grant_idx
);
   assign grant_valid = |req;
   assign grant_idx   = req[prio] ? prio : !prio;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between the control unit (0) and
// the feature-extraction engine (1) with round-robin grant and per-requester responses
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [5:0]       req0_fn,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [5:0]       req1_fn,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_y,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_y,
   output logic             rsp1_err,
   output logic [5:0]       alu_fn,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic             busy
);
   state_t           state_q;
   logic             prio_q, owner_q, illegal_q, err_q;
   logic [5:0]       alu_fn_q, fn_d;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, y_q, a_d, b_d;
   logic             grant_valid, grant_idx, idle, rsp_ready;

   rr_arb2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .prio       (prio_q),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx)
   );

   // ready is gated by reset so nothing is offered while reset is held
   assign idle       = state_q == ST_IDLE && !reset;
   assign req0_ready = idle && grant_valid && !grant_idx;
   assign req1_ready = idle && grant_valid && grant_idx;
   assign fn_d       = grant_idx ? req1_fn : req0_fn;
   assign a_d        = grant_idx ? req1_a : req0_a;
   assign b_d        = grant_idx ? req1_b : req0_b;
   assign rsp_ready  = owner_q ? rsp1_ready : rsp0_ready;
   assign rsp0_valid = state_q == ST_RESP && !owner_q;
   assign rsp1_valid = state_q == ST_RESP && owner_q;
   assign rsp0_y     = rsp0_valid ? y_q : '0;
   assign rsp1_y     = rsp1_valid ? y_q : '0;
   assign rsp0_err   = rsp0_valid && err_q;
   assign rsp1_err   = rsp1_valid && err_q;
   assign alu_fn     = alu_fn_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign busy       = state_q != ST_IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         prio_q    <= 1'b0;
         owner_q   <= 1'b0;
         illegal_q <= 1'b0;
         err_q     <= 1'b0;
         alu_fn_q  <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         y_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (grant_valid) begin
               alu_fn_q  <= fn_d;
               alu_a_q   <= a_d;
               alu_b_q   <= b_d;
               owner_q   <= grant_idx;
               illegal_q <= !alufn_legal(fn_d);
               state_q   <= ST_EXEC;
            end
            ST_EXEC: begin
               y_q     <= illegal_q ? '0 : alu_y;
               err_q   <= illegal_q;
               state_q <= ST_RESP;
            end
            ST_RESP: if (rsp_ready) begin
               prio_q  <= !owner_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed requests with hand-computed results; a monitor pops
// per-requester expectation queues on every response handshake
module tb_alu_share_ctrl;
   typedef struct {
      logic [31:0] y;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [5:0]  req0_fn = '0, req1_fn = '0, alu_fn;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid, rsp0_ready = 1, rsp1_ready = 1, rsp0_err, rsp1_err, busy;
   logic [31:0] rsp0_y, rsp1_y, alu_a, alu_b, alu_y;

   exp_t        q0[$], q1[$];
   logic [31:0] pend0_y, pend1_y;
   logic        pend0_err, pend1_err, seen0 = 0, seen1 = 0;
   int          cyc = 0, acc0 = 0, acc1 = 0, hs0 = 0, checks = 0, errors = 0;

   alu_share_ctrl dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_err(rsp1_err),
      .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // reference ALU; unknown opcodes return a poison value the controller must mask
   always_comb begin
      case (alu_fn)
         6'b100000: alu_y = alu_a + alu_b;
         6'b100001: alu_y = alu_a - alu_b;
         6'b100100: alu_y = 32'(alu_a == alu_b);
         6'b100101: alu_y = 32'($signed(alu_a) < $signed(alu_b));
         6'b100110: alu_y = 32'($signed(alu_a) <= $signed(alu_b));
         6'b101000: alu_y = alu_a & alu_b;
         6'b101001: alu_y = alu_a | alu_b;
         6'b101010: alu_y = alu_a ^ alu_b;
         6'b101011: alu_y = ~(alu_a ^ alu_b);
         6'b101100: alu_y = alu_a << alu_b[4:0];
         6'b101101: alu_y = alu_a >> alu_b[4:0];
         6'b101110: alu_y = $signed(alu_a) >>> alu_b[4:0];
         6'b111111: alu_y = alu_a;
         default:   alu_y = 32'hDEADBEEF;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (req0_valid && req0_ready) begin q0.push_back(exp_t'{pend0_y, pend0_err, cyc}); acc0 = cyc; end
         if (req1_valid && req1_ready) begin q1.push_back(exp_t'{pend1_y, pend1_err, cyc}); acc1 = cyc; end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q0.delete(); q1.delete(); seen0 = 0; seen1 = 0;
      end else begin
         if (rsp0_valid || rsp1_valid) chk("no_req_ready_in_resp", 32'(req0_ready | req1_ready), 0);
         if (rsp0_valid) begin
            chk("rsp_exclusive", 32'(rsp1_valid), 0);
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp0_unexpected y %h", rsp0_y);
            end else begin
               if (!seen0) begin chk("rsp0_latency", cyc, q0[0].acc + 2); seen0 = 1; end
               if (rsp0_ready) begin
                  chk("rsp0_y", rsp0_y, q0[0].y);
                  chk("rsp0_err", 32'(rsp0_err), 32'(q0[0].err));
                  void'(q0.pop_front()); seen0 = 0; hs0 = cyc;
               end
            end
         end
         if (rsp1_valid) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp1_unexpected y %h", rsp1_y);
            end else begin
               if (!seen1) begin chk("rsp1_latency", cyc, q1[0].acc + 2); seen1 = 1; end
               if (rsp1_ready) begin
                  chk("rsp1_y", rsp1_y, q1[0].y);
                  chk("rsp1_err", 32'(rsp1_err), 32'(q1[0].err));
                  void'(q1.pop_front()); seen1 = 0;
               end
            end
         end
      end
   end

   task automatic issue(input int idx, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic ee);
      if (idx == 0) begin
         req0_valid = 1; req0_fn = fn; req0_a = a; req0_b = b; pend0_y = ey; pend0_err = ee;
      end else begin
         req1_valid = 1; req1_fn = fn; req1_a = a; req1_b = b; pend1_y = ey; pend1_err = ee;
      end
   endtask

   task automatic await_accept(input int idx);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = idx == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      end
      if (!ok) begin checks++; errors++; $display("FAIL accept%0d timeout", idx); end
      @(posedge clk); #1;
      if (idx == 0) req0_valid = 0; else req1_valid = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0 || busy); i++) begin
         @(posedge clk); #1;
      end
      if (q0.size() != 0 || q1.size() != 0 || busy) begin
         checks++; errors++;
         $display("FAIL idle timeout pending %0d/%0d", q0.size(), q1.size());
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
      chk("rst_alu_fn", 32'(alu_fn), 0);
      chk("rst_alu_ab", alu_a | alu_b, 0);
      // contention straight out of reset: requester 0 first, then 1
      issue(0, 6'b100001, 10, 3, 7, 0);
      issue(1, 6'b101010, 32'hF0, 32'hFF, 32'h0F, 0);
      #1 chk("rst_req_ready", 32'({req1_ready, req0_ready}), 0);
      @(negedge clk) reset = 0;
      await_accept(0);
      chk("alu_fn_latch", 32'(alu_fn), 32'(6'b100001));
      chk("alu_a_latch", alu_a, 10);
      chk("alu_b_latch", alu_b, 3);
      await_accept(1);
      chk("contention_order", acc1, acc0 + 3);
      wait_idle();
      // single op
      issue(0, 6'b100000, 5, 7, 12, 0);
      await_accept(0);
      wait_idle();
      chk("alu_a_hold_idle", alu_a, 5);
      // prio now favours requester 1
      issue(0, 6'b100101, 32'hFFFFFFFF, 1, 1, 0);
      issue(1, 6'b101110, 32'h80000000, 4, 32'hF8000000, 0);
      await_accept(1);
      await_accept(0);
      chk("prio_order", acc0, acc1 + 3);
      wait_idle();
      // backpressure on requester 0 with requester 1 waiting
      rsp0_ready = 0;
      issue(0, 6'b101000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0);
      await_accept(0);
      issue(1, 6'b100000, 1, 2, 3, 0);
      for (int i = 0; i < 10 && !rsp0_valid; i++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", 32'(rsp0_valid), 1);
         chk("bp_y", rsp0_y, 32'h0F000F00);
         chk("bp_req1_ready", 32'(req1_ready), 0);
         if (k < 3) @(negedge clk);
      end
      @(posedge clk); #1 rsp0_ready = 1;
      await_accept(1);
      chk("bp_req1_after_hs", acc1, hs0 + 1);
      wait_idle();
      // illegal opcodes and the highest legal one
      issue(1, 6'b000000, 3, 4, 0, 1);
      await_accept(1);
      wait_idle();
      issue(0, 6'b111110, 9, 9, 0, 1);
      await_accept(0);
      wait_idle();
      issue(0, 6'b111111, 32'h1234, 5, 32'h1234, 0);
      await_accept(0);
      wait_idle();
      // reset during EXEC drops the transaction and restores prio 0
      issue(0, 6'b100000, 1, 1, 2, 0);
      await_accept(0);
      chk("pre_reset_busy", 32'(busy), 1);
      reset = 1;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
      chk("midrst_alu_fn", 32'(alu_fn), 0);
      chk("midrst_alu_ab", alu_a | alu_b, 0);
      issue(0, 6'b100001, 9, 4, 5, 0);
      issue(1, 6'b101001, 1, 2, 3, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      await_accept(0);
      await_accept(1);
      chk("post_reset_order", acc1, acc0 + 3);
      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1);
   end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares one 32-bit combinational ALU between two requesters: requester 0 is the control unit and requester 1 is the fingerprint feature-extraction engine. It accepts operations over valid/ready request channels and grants round-robin. It registers the operands, drives the ALU and captures its result, then returns the result on a per-requester valid/ready response channel. It sits between the requesters and the single ALU instance, replacing direct ALU drive.

## Interface
- WIDTH, 32, datapath width of operands and result
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_fn / req1_fn  in  6  ALUFN opcode
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands, signed
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp0_y / rsp1_y  out  WIDTH  result
- rsp0_err / rsp1_err  out  1  opcode was not a legal ALUFN
- alu_fn  out  6  to ALU ALUFN, registered
- alu_a, alu_b  out  WIDTH  to ALU A/B, registered
- alu_y  in  WIDTH  from ALU Y, combinational
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, the grant goes to the requester selected by round-robin pointer `prio`. The pointer value has priority; the other requester wins only if the preferred one is idle.
  - reqN_ready = (state==IDLE) && grant==N, combinational. The ungranted requester sees ready=0.
  - On handshake: latch fn/a/b into alu_fn/alu_a/alu_b, latch owner, compute and latch `illegal`, then go to EXEC.
- EXEC: the ALU settles from the registered operands. At the end of the cycle the result register captures alu_y, or 0 if `illegal`; err captures `illegal`. Go to RESP.
- RESP:
  - rsp[owner]_valid=1, with rsp_y/rsp_err from the result registers. The non-owner rsp_valid stays 0.
  - The response stays stable until rsp[owner]_ready=1.
  - On handshake: set prio = ~owner, go to IDLE.
- Legal opcodes are 100000, 100001, 100100, 100101, 100110, 101000, 101001, 101010, 101011, 101100, 101101, 101110 and 111111. Any other opcode is illegal. An illegal opcode still takes the full EXEC path, so latency is uniform.
- The controller never modifies operands. Signedness and shift semantics belong to the ALU.
- rsp_y of a non-owner requester is don't-care; drive it 0.

## Timing
- Reset values: state IDLE, prio 0, owner 0, alu_fn/alu_a/alu_b 0, result 0, err 0. All rsp*_valid, req*_ready and busy are 0 while reset is asserted.
- Latency: request handshake in cycle T, EXEC in T+1, rsp_valid high in T+2.
- Minimum initiation interval: 3 cycles (accept, EXEC, RESP with immediate ready). The next acceptance is possible in T+3.
- alu_fn/alu_a/alu_b hold their last values through IDLE and change only on request acceptance.
- Simultaneous valid after reset: requester 0 is served first.
- Requester backpressure: while in RESP both req*_ready stay 0, and the response holds indefinitely.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is issued. State returns to IDLE and prio to 0.
- A requester may drop valid before ready without a protocol error, because no state is changed.

## Structure
- Shared package alu_pkg: ALUFN localparams (ALU_ADD, ALU_SUB, ALU_CMPEQ, ALU_CMPLT, ALU_CMPLE, ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR, ALU_A, ALU_SHL, ALU_SHR, ALU_SRA), the function alufn_legal(fn), and the FSM state encodings.
- Sub-module rr_arb2 holds the two-input round-robin grant: inputs req[1:0] and prio; outputs grant_valid and grant_idx.
- The top-level module contains the FSM, the operand/result registers and the response muxing.

## Test plan
- Single op: req0 fn=100000, A=5, B=7, accepted at T → rsp0_valid at T+2, rsp0_y=12, rsp0_err=0, rsp1_valid=0.
- Contention: both valid from reset. req0 is 100001 with 10,3; req1 is 101010 with 0xF0,0xFF. Expected: rsp0_y=7 first, then req1 accepted, rsp1_y=0x0F. The next simultaneous pair grants req1 first if prio is 1.
- Backpressure: rsp0_ready held 0 for 4 cycles → rsp0_valid/rsp0_y stable, req1_ready=0 throughout, req1 accepted in the cycle after the handshake.
- Illegal opcode: req1 fn=000000, A=3, B=4 → rsp1_valid at T+2, rsp1_err=1, rsp1_y=0.
- Signed compare and shift:
  - fn=100101, A=-1, B=1 → y=1.
  - fn=101110, A=0x80000000, B=4 → y=0xF8000000.
- Reset mid-op: assert reset during EXEC → no rsp*_valid, busy=0, all outputs at reset values. With both requesting after release, req0 is granted.
